// File: rtl/countdown_timer_if.sv
// Switch/LED/hexdigit bundle between the countdown timer and the board I/O.
interface countdown_timer_if;
   logic [9:0] stswi;
   logic [9:0] stled;
   logic [4:0] data_0;
   logic [4:0] data_1;
   logic [4:0] data_2;
   logic [4:0] data_3;
   logic       dp;
   logic       done;

   modport master (
      output stswi,
      input  stled, data_0, data_1, data_2, data_3, dp, done
   );

   modport slave (
      input  stswi,
      output stled, data_0, data_1, data_2, data_3, dp, done
   );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: switch-loaded preset, one-second BCD decrement, expiry
// blink on the hexdigits. Display outputs decode straight from the registers.
module countdown_timer #(
   parameter logic [5:0] MAX_MIN   = 6'd59,
   parameter logic [4:0] IDLE_CODE = 5'd18,
   parameter logic [4:0] EXP_CODE  = 5'd17,
   parameter logic [4:0] OFF_CODE  = 5'd20
) (
   input  logic               clk_1hz,
   input  logic               rst,
   countdown_timer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOADED  = 3'd1,
      S_RUN     = 3'd2,
      S_PAUSE   = 3'd3,
      S_EXPIRED = 3'd4
   } state_t;

   state_t     state, state_n;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic [3:0] sec_ones_n, sec_tens_n, min_ones_n, min_tens_n;
   logic       phase, phase_n;

   logic       load, run;
   logic [5:0] preset;
   logic [3:0] pre_tens, pre_ones;
   logic       is_zero, is_one;

   assign load = bus.stswi[9];
   assign run  = bus.stswi[8];

   // Clamp the minutes preset and split it into BCD tens/ones.
   assign preset   = (bus.stswi[5:0] > MAX_MIN) ? MAX_MIN : bus.stswi[5:0];
   assign pre_tens = 4'(preset / 6'd10);
   assign pre_ones = 4'(preset % 6'd10);

   assign is_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);
   assign is_one  = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd1);

   always_ff @(posedge clk_1hz or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
         phase    <= 1'b0;
      end else begin
         state    <= state_n;
         sec_ones <= sec_ones_n;
         sec_tens <= sec_tens_n;
         min_ones <= min_ones_n;
         min_tens <= min_tens_n;
         phase    <= phase_n;
      end
   end

   always_comb begin
      state_n    = state;
      sec_ones_n = sec_ones;
      sec_tens_n = sec_tens;
      min_ones_n = min_ones;
      min_tens_n = min_tens;
      phase_n    = 1'b0;

      if (load) begin
         state_n    = S_LOADED;
         min_tens_n = pre_tens;
         min_ones_n = pre_ones;
         sec_tens_n = 4'd0;
         sec_ones_n = 4'd0;
      end else begin
         case (state)
            S_IDLE: ;
            S_LOADED: if (run) state_n = is_zero ? S_EXPIRED : S_RUN;
            S_RUN: begin
               if (!run) begin
                  state_n = S_PAUSE;
               end else if (is_zero) begin
                  state_n = S_EXPIRED;
               end else begin
                  // BCD borrow chain, seconds up through minutes tens
                  if (sec_ones != 4'd0) begin
                     sec_ones_n = sec_ones - 4'd1;
                  end else begin
                     sec_ones_n = 4'd9;
                     if (sec_tens != 4'd0) begin
                        sec_tens_n = sec_tens - 4'd1;
                     end else begin
                        sec_tens_n = 4'd5;
                        if (min_ones != 4'd0) begin
                           min_ones_n = min_ones - 4'd1;
                        end else begin
                           min_ones_n = 4'd9;
                           min_tens_n = min_tens - 4'd1;
                        end
                     end
                  end
                  if (is_one) state_n = S_EXPIRED;
               end
            end
            S_PAUSE:   if (run) state_n = S_RUN;
            S_EXPIRED: ;
            default:   state_n = S_IDLE;
         endcase
      end

      // Phase only advances while the display is live-counting or blinking.
      if ((state_n == S_RUN) || (state_n == S_EXPIRED)) phase_n = ~phase;
   end

   always_comb begin
      bus.data_0 = IDLE_CODE;
      bus.data_1 = IDLE_CODE;
      bus.data_2 = IDLE_CODE;
      bus.data_3 = IDLE_CODE;
      bus.dp     = 1'b0;
      bus.done   = 1'b0;
      bus.stled  = 10'b0000000001;

      case (state)
         S_LOADED, S_RUN, S_PAUSE: begin
            bus.data_0 = {1'b0, sec_ones};
            bus.data_1 = {1'b0, sec_tens};
            bus.data_2 = {1'b0, min_ones};
            bus.data_3 = {1'b0, min_tens};
         end
         S_EXPIRED: begin
            bus.data_0 = phase ? EXP_CODE : OFF_CODE;
            bus.data_1 = phase ? EXP_CODE : OFF_CODE;
            bus.data_2 = phase ? EXP_CODE : OFF_CODE;
            bus.data_3 = phase ? EXP_CODE : OFF_CODE;
            bus.done   = 1'b1;
         end
         default: ;
      endcase

      case (state)
         S_LOADED:  bus.stled = 10'b0000000010;
         S_RUN:     begin bus.stled = 10'b0000000100; bus.dp = phase; end
         S_PAUSE:   begin bus.stled = 10'b0000001000; bus.dp = 1'b1;  end
         S_EXPIRED: bus.stled = 10'b1000010000;
         default:   bus.stled = 10'b0000000001;
      endcase
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table plus expiry and reset sequences.
module tb_countdown_timer;

   logic clk_1hz;
   logic rst;
   countdown_timer_if bus ();

   countdown_timer dut (
      .clk_1hz (clk_1hz),
      .rst     (rst),
      .bus     (bus)
   );

   initial clk_1hz = 1'b0;
   always #5 clk_1hz = ~clk_1hz;

   typedef struct {
      logic [9:0]  sw;
      logic [9:0]  led;
      logic [19:0] data;
      logic        dp;
   } vec_t;

   localparam logic [9:0] L_IDLE = 10'h001;
   localparam logic [9:0] L_LD   = 10'h002;
   localparam logic [9:0] L_RUN  = 10'h004;
   localparam logic [9:0] L_PS   = 10'h008;
   localparam logic [9:0] L_EXP  = 10'h210;

   int checks = 0;
   int errors = 0;

   function automatic logic [19:0] dg(input int d3, input int d2, input int d1, input int d0);
      return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
   endfunction

   function automatic logic [19:0] secs_to_data(input int s);
      int m, r;
      m = s / 60;
      r = s % 60;
      return dg(m / 10, m % 10, r / 10, r % 10);
   endfunction

   function automatic vec_t mk(input logic [9:0] sw, input logic [9:0] led,
                               input logic [19:0] data, input logic dp);
      vec_t v;
      v.sw = sw; v.led = led; v.data = data; v.dp = dp;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [9:0] led,
                            input logic [19:0] data, input logic dp);
      check({tag, ".stled"}, 32'(bus.stled), 32'(led));
      check({tag, ".data"},  32'({bus.data_3, bus.data_2, bus.data_1, bus.data_0}), 32'(data));
      check({tag, ".dp"},    32'(bus.dp), 32'(dp));
      check({tag, ".done"},  32'(bus.done), 32'(led[9]));
   endtask

   task automatic step(input logic [9:0] sw);
      @(negedge clk_1hz);
      bus.stswi = sw;
      @(posedge clk_1hz);
      #1;
   endtask

   vec_t tbl[23];

   initial begin
      logic [19:0] all17, all20, all18;
      int s;
      logic ph;

      all17 = dg(17, 17, 17, 17);
      all20 = dg(20, 20, 20, 20);
      all18 = dg(18, 18, 18, 18);

      tbl[0]  = mk(10'h205, L_LD,  dg(0, 5, 0, 0), 1'b0);
      tbl[1]  = mk(10'h100, L_RUN, dg(0, 5, 0, 0), 1'b1);
      tbl[2]  = mk(10'h100, L_RUN, dg(0, 4, 5, 9), 1'b0);
      tbl[3]  = mk(10'h100, L_RUN, dg(0, 4, 5, 8), 1'b1);
      tbl[4]  = mk(10'h000, L_PS,  dg(0, 4, 5, 8), 1'b1);
      tbl[5]  = mk(10'h000, L_PS,  dg(0, 4, 5, 8), 1'b1);
      tbl[6]  = mk(10'h000, L_PS,  dg(0, 4, 5, 8), 1'b1);
      tbl[7]  = mk(10'h100, L_RUN, dg(0, 4, 5, 8), 1'b1);
      tbl[8]  = mk(10'h100, L_RUN, dg(0, 4, 5, 7), 1'b0);
      tbl[9]  = mk(10'h20A, L_LD,  dg(1, 0, 0, 0), 1'b0);
      tbl[10] = mk(10'h100, L_RUN, dg(1, 0, 0, 0), 1'b1);
      tbl[11] = mk(10'h100, L_RUN, dg(0, 9, 5, 9), 1'b0);
      tbl[12] = mk(10'h201, L_LD,  dg(0, 1, 0, 0), 1'b0);
      tbl[13] = mk(10'h100, L_RUN, dg(0, 1, 0, 0), 1'b1);
      tbl[14] = mk(10'h100, L_RUN, dg(0, 0, 5, 9), 1'b0);
      tbl[15] = mk(10'h23F, L_LD,  dg(5, 9, 0, 0), 1'b0);
      tbl[16] = mk(10'h33F, L_LD,  dg(5, 9, 0, 0), 1'b0);
      tbl[17] = mk(10'h200, L_LD,  dg(0, 0, 0, 0), 1'b0);
      tbl[18] = mk(10'h100, L_EXP, all17,          1'b0);
      tbl[19] = mk(10'h000, L_EXP, all20,          1'b0);
      tbl[20] = mk(10'h100, L_EXP, all17,          1'b0);
      tbl[21] = mk(10'h200, L_LD,  dg(0, 0, 0, 0), 1'b0);
      tbl[22] = mk(10'h2C7, L_LD,  dg(0, 7, 0, 0), 1'b0);

      rst = 1'b0;
      bus.stswi = 10'h000;
      #12;
      check_all("reset", L_IDLE, all18, 1'b0);
      @(negedge clk_1hz);
      rst = 1'b1;

      // IDLE ignores run; only load leaves it
      step(10'h100);
      check_all("idle_run", L_IDLE, all18, 1'b0);

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].sw);
         check_all($sformatf("vec%0d", i), tbl[i].led, tbl[i].data, tbl[i].dp);
      end

      // One-minute preset run down to expiry, checked every edge
      step(10'h201);
      check_all("exp_load", L_LD, dg(0, 1, 0, 0), 1'b0);
      step(10'h100);
      check_all("exp_start", L_RUN, dg(0, 1, 0, 0), 1'b1);
      s  = 60;
      ph = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         step(10'h100);
         s--;
         ph = ~ph;
         if (s > 0) check_all($sformatf("cd%0d", s), L_RUN, secs_to_data(s), ph);
         else       check_all("cd_expire", L_EXP, ph ? all17 : all20, 1'b0);
      end
      step(10'h000);
      check_all("exp_hold0", L_EXP, all20, 1'b0);
      step(10'h100);
      check_all("exp_hold1", L_EXP, all17, 1'b0);
      step(10'h200);
      check_all("exp_reload", L_LD, dg(0, 0, 0, 0), 1'b0);
      step(10'h201);
      check_all("exp_reload1", L_LD, dg(0, 1, 0, 0), 1'b0);

      // Asynchronous reset in the middle of a run
      step(10'h205);
      step(10'h100);
      step(10'h100);
      check_all("pre_rst", L_RUN, dg(0, 4, 5, 9), 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_all("mid_rst", L_IDLE, all18, 1'b0);
      @(negedge clk_1hz);
      rst = 1'b1;
      step(10'h100);
      check_all("post_rst", L_IDLE, all18, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
